// File: rtl/ysyx_22050019_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - lsu_state_e  : FSM state encoding (IDLE/REQ/WAIT/RESP)
//   - R_* / W_*    : bit positions inside the decoder width codes
//                    in_r_wdth = {lw,lh,lb,lwu,lhu,lbu}, in_w_wdth = {sd,sb,sh,sw}
//   - SZ_*         : access size code (log2 of byte count)
//   - CNT_W        : width of the WAIT timeout counter
//   - decode_load / decode_store : width code -> {size, sign-extend}
package ysyx_22050019_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam int R_LW  = 5;
    localparam int R_LH  = 4;
    localparam int R_LB  = 3;
    localparam int R_LWU = 2;
    localparam int R_LHU = 1;
    localparam int R_LBU = 0;

    localparam int W_SD = 3;
    localparam int W_SB = 2;
    localparam int W_SH = 1;
    localparam int W_SW = 0;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [1:0] size;
        logic       sext;
    } acc_fmt_t;

    // An all-zero load code is ld; if several bits are set the first one
    // in {lw,lh,lb,lwu,lhu,lbu} order wins.
    function automatic acc_fmt_t decode_load(input logic [5:0] code);
        acc_fmt_t f;
        if (code[R_LW]) begin
            f.size = SZ_W; f.sext = 1'b1;
        end else if (code[R_LH]) begin
            f.size = SZ_H; f.sext = 1'b1;
        end else if (code[R_LB]) begin
            f.size = SZ_B; f.sext = 1'b1;
        end else if (code[R_LWU]) begin
            f.size = SZ_W; f.sext = 1'b0;
        end else if (code[R_LHU]) begin
            f.size = SZ_H; f.sext = 1'b0;
        end else if (code[R_LBU]) begin
            f.size = SZ_B; f.sext = 1'b0;
        end else begin
            f.size = SZ_D; f.sext = 1'b0;
        end
        return f;
    endfunction

    // An all-zero store code is a 64-bit store.
    function automatic acc_fmt_t decode_store(input logic [3:0] code);
        acc_fmt_t f;
        f.sext = 1'b0;
        if (code[W_SD]) begin
            f.size = SZ_D;
        end else if (code[W_SB]) begin
            f.size = SZ_B;
        end else if (code[W_SH]) begin
            f.size = SZ_H;
        end else if (code[W_SW]) begin
            f.size = SZ_W;
        end else begin
            f.size = SZ_D;
        end
        return f;
    endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_align.sv
// Byte-lane steering for the LSU (purely combinational).
//   lane      : byte offset inside the 64-bit word (addr[2:0])
//   size      : SZ_B/H/W/D
//   sext      : sign-extend the extracted load value
//   wdata     : store value, in the low bytes
//   rdata     : aligned 64-bit word from the bus
//   wstrb     : byte strobes for the store
//   wdata_sh  : store value moved onto its lane
//   rdata_ext : load value moved to bit 0 and extended
//   misalign  : access does not sit on its natural boundary
module ysyx_22050019_lsu_align
    import ysyx_22050019_lsu_pkg::*;
(
    input  logic [2:0]  lane,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext,
    output logic        misalign
);

    logic [63:0] rsh_s;

    // Strobes, lane-shifted write data and the alignment check.
    always_comb begin
        wdata_sh = wdata << {lane, 3'b000};
        case (size)
            SZ_B: begin
                wstrb    = 8'h01 << lane;
                misalign = 1'b0;
            end
            SZ_H: begin
                wstrb    = 8'h03 << lane;
                misalign = lane[0];
            end
            SZ_W: begin
                wstrb    = 8'h0F << lane;
                misalign = |lane[1:0];
            end
            default: begin
                wstrb    = 8'hFF;
                misalign = |lane;
            end
        endcase
    end

    // Bring the addressed bytes down to bit 0, then extend to 64 bits.
    always_comb begin
        rsh_s = rdata >> {lane, 3'b000};
        case (size)
            SZ_B: rdata_ext = {{56{sext & rsh_s[7]}},  rsh_s[7:0]};
            SZ_H: rdata_ext = {{48{sext & rsh_s[15]}}, rsh_s[15:0]};
            SZ_W: rdata_ext = {{32{sext & rsh_s[31]}}, rsh_s[31:0]};
            default: rdata_ext = rsh_s;
        endcase
    end

endmodule

// File: rtl/ysyx_22050019_lsu.sv
// Load/store unit. Accepts one access per in_valid/in_ready handshake,
// issues an aligned 64-bit request on the data-memory bus, and returns
// extended load data (or 0 for stores/errors) to writeback.
//   in_*      : access from EXU (re/we, width codes, address, store data)
//   out_*     : result to WBU (valid/ready, rdata, err)
//   mem_req_* : request channel to data memory (held stable until ready)
//   mem_rsp_* : single-cycle response pulse from data memory
// Misaligned and no-op accesses complete without touching the bus.
// A WAIT lasting TIMEOUT cycles is aborted with out_err=1.
module ysyx_22050019_lsu
    import ysyx_22050019_lsu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_re,
    input  logic              in_we,
    input  logic [5:0]        in_r_wdth,
    input  logic [3:0]        in_w_wdth,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    input  logic              mem_rsp_err
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    lsu_state_e        state_r, state_n;
    logic              in_ready_r, req_valid_r, out_valid_r;
    logic              req_we_r, req_we_n;
    logic [63:0]       req_addr_r, req_addr_n;
    logic [63:0]       req_wdata_r, req_wdata_n;
    logic [7:0]        req_wstrb_r, req_wstrb_n;
    logic [2:0]        lane_r, lane_n;
    acc_fmt_t          fmt_r, fmt_n;
    logic [63:0]       rdata_r, rdata_n;
    logic              err_r, err_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;

    acc_fmt_t          in_fmt_s, al_fmt_s;
    logic [2:0]        al_lane_s;
    logic [7:0]        al_wstrb_s;
    logic [63:0]       al_wdata_s, al_rdata_s;
    logic              al_mis_s;

    // Width decode of the incoming access; re wins when both re and we are set.
    always_comb begin
        if (in_re) begin
            in_fmt_s = decode_load(in_r_wdth);
        end else begin
            in_fmt_s = decode_store(in_w_wdth);
        end
    end

    // The aligner serves the request side in IDLE and the response side later.
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_lane_s = in_addr[2:0];
            al_fmt_s  = in_fmt_s;
        end else begin
            al_lane_s = lane_r;
            al_fmt_s  = fmt_r;
        end
    end

    ysyx_22050019_lsu_align u_align (
        .lane      (al_lane_s),
        .size      (al_fmt_s.size),
        .sext      (al_fmt_s.sext),
        .wdata     (in_wdata),
        .rdata     (mem_rsp_rdata),
        .wstrb     (al_wstrb_s),
        .wdata_sh  (al_wdata_s),
        .rdata_ext (al_rdata_s),
        .misalign  (al_mis_s)
    );

    // Next-state and next-value logic for the access FSM.
    always_comb begin
        state_n     = state_r;
        req_we_n    = req_we_r;
        req_addr_n  = req_addr_r;
        req_wdata_n = req_wdata_r;
        req_wstrb_n = req_wstrb_r;
        lane_n      = lane_r;
        fmt_n       = fmt_r;
        rdata_n     = rdata_r;
        err_n       = err_r;
        cnt_n       = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    req_we_n    = in_we & ~in_re;
                    req_addr_n  = {in_addr[63:3], 3'b000};
                    lane_n      = in_addr[2:0];
                    fmt_n       = in_fmt_s;
                    cnt_n       = {CNT_W{1'b0}};
                    rdata_n     = 64'd0;
                    if (in_we & ~in_re) begin
                        req_wdata_n = al_wdata_s;
                        req_wstrb_n = al_wstrb_s;
                    end else begin
                        req_wdata_n = 64'd0;
                        req_wstrb_n = 8'h00;
                    end
                    if (!in_re && !in_we) begin
                        state_n = ST_RESP;
                        err_n   = 1'b0;
                    end else if (al_mis_s) begin
                        state_n = ST_RESP;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ST_REQ;
                        err_n   = 1'b0;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_n = ST_WAIT;
                    cnt_n   = {CNT_W{1'b0}};
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_WAIT: begin
                cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mem_rsp_valid) begin
                    state_n = ST_RESP;
                    err_n   = mem_rsp_err;
                    if (req_we_r || mem_rsp_err) begin
                        rdata_n = 64'd0;
                    end else begin
                        rdata_n = al_rdata_s;
                    end
                end else if (cnt_n == TO_LIMIT) begin
                    state_n = ST_RESP;
                    err_n   = 1'b1;
                    rdata_n = 64'd0;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                    rdata_n = 64'd0;
                    err_n   = 1'b0;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake outputs follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            req_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
            req_we_r    <= 1'b0;
            req_addr_r  <= 64'd0;
            req_wdata_r <= 64'd0;
            req_wstrb_r <= 8'h00;
            lane_r      <= 3'd0;
            fmt_r       <= '0;
            rdata_r     <= 64'd0;
            err_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == ST_IDLE);
            req_valid_r <= (state_n == ST_REQ);
            out_valid_r <= (state_n == ST_RESP);
            req_we_r    <= req_we_n;
            req_addr_r  <= req_addr_n;
            req_wdata_r <= req_wdata_n;
            req_wstrb_r <= req_wstrb_n;
            lane_r      <= lane_n;
            fmt_r       <= fmt_n;
            rdata_r     <= rdata_n;
            err_r       <= err_n;
            cnt_r       <= cnt_n;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_rdata     = rdata_r;
    assign out_err       = err_r;
    assign mem_req_valid = req_valid_r;
    assign mem_req_we    = req_we_r & req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_wdata = req_wdata_r;
    assign mem_req_wstrb = req_wstrb_r;

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Self-checking bench for the load/store unit: directed scenarios plus
// randomized accesses, compared against a byte-level reference model.
module tb_ysyx_22050019_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_re, in_we;
    logic [5:0]  in_r_wdth;
    logic [3:0]  in_w_wdth;
    logic [63:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_err;
    logic [63:0] out_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [63:0] mem_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050019_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_we(in_we),
        .in_r_wdth(in_r_wdth), .in_w_wdth(in_w_wdth),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_err(mem_rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full access: drive, emulate the bus, check request and result.
    // rsp_dly < 0 means the bus never answers (timeout expected).
    task automatic run_access(input string name, input logic re, input logic we,
                              input logic [5:0] rc, input logic [3:0] wc,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input logic [63:0] rword, input logic rerr,
                              input int rdy_dly, input int rsp_dly, input int ordy_dly);
        int nb; bit sgn; bit load; bit noop; bit mis; int lane; int cyc; int k;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata, e_rdata, v;
        logic        e_err;
        load = re; noop = !re && !we; lane = int'(addr[2:0]);
        sgn = 1'b0; nb = 8;
        if (load) begin
            case (rc)
                6'b100000: begin nb = 4; sgn = 1'b1; end
                6'b010000: begin nb = 2; sgn = 1'b1; end
                6'b001000: begin nb = 1; sgn = 1'b1; end
                6'b000100: nb = 4;
                6'b000010: nb = 2;
                6'b000001: nb = 1;
                default:   nb = 8;
            endcase
        end else begin
            case (wc)
                4'b0100: nb = 1;
                4'b0010: nb = 2;
                4'b0001: nb = 4;
                default: nb = 8;
            endcase
        end
        mis = !noop && ((lane % nb) != 0);
        e_strb = 8'h00; e_wdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (!load && i >= lane && i < lane + nb) e_strb[i] = 1'b1;
            if (i >= lane) e_wdata[8*i +: 8] = wd[8*(i-lane) +: 8];
        end
        v = 64'd0;
        for (int i = 0; i < nb; i++) if (lane + i < 8) v[8*i +: 8] = rword[8*(lane+i) +: 8];
        if (sgn && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        if (noop)              begin e_rdata = 64'd0; e_err = 1'b0; end
        else if (mis)          begin e_rdata = 64'd0; e_err = 1'b1; end
        else if (rsp_dly < 0)  begin e_rdata = 64'd0; e_err = 1'b1; end
        else if (!load || rerr) begin e_rdata = 64'd0; e_err = rerr; end
        else                   begin e_rdata = v; e_err = 1'b0; end

        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready); end
        in_valid = 1'b1; in_re = re; in_we = we; in_r_wdth = rc; in_w_wdth = wc;
        in_addr = addr; in_wdata = wd;
        tick();
        in_valid = 1'b0; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        cyc = 1;
        if (noop || mis) begin
            checks++;
            if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s no_req: mem_req_valid got %b want 0", name, mem_req_valid); end
        end else begin
            for (k = 0; k <= rdy_dly; k++) begin
                checks++;
                if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb} !==
                    {1'b1, !load, addr & ~64'h7, e_strb}) begin
                    errors++;
                    $display("FAIL %s req: got v=%b we=%b a=%h s=%h want v=1 we=%b a=%h s=%h",
                             name, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb,
                             !load, addr & ~64'h7, e_strb);
                end
                if (!load) begin
                    checks++;
                    if (mem_req_wdata !== e_wdata) begin errors++; $display("FAIL %s wdata: got %h want %h", name, mem_req_wdata, e_wdata); end
                end
                if (k == rdy_dly) mem_req_ready = 1'b1;
                tick(); cyc++;
                mem_req_ready = 1'b0;
            end
            if (rsp_dly < 0) begin
                k = 0;
                while (out_valid !== 1'b1 && k < 300) begin tick(); k++; end
                checks++;
                if (k != 255) begin errors++; $display("FAIL %s timeout_cycles: got %0d want 255", name, k); end
                mem_rsp_valid = 1'b1; mem_rsp_rdata = rword; mem_rsp_err = 1'b0;
                tick();
                mem_rsp_valid = 1'b0;
            end else begin
                for (k = 0; k < rsp_dly; k++) begin tick(); cyc++; end
                mem_rsp_valid = 1'b1; mem_rsp_rdata = rword; mem_rsp_err = rerr;
                tick(); cyc++;
                mem_rsp_valid = 1'b0; mem_rsp_rdata = {$urandom, $urandom}; mem_rsp_err = 1'b0;
            end
        end
        if (rsp_dly >= 0) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL %s latency: out_valid=%b at cycle %0d", name, out_valid, cyc); end
        end
        for (k = 0; k <= ordy_dly; k++) begin
            checks++;
            if ({out_valid, out_err, out_rdata} !== {1'b1, e_err, e_rdata}) begin
                errors++;
                $display("FAIL %s result: got v=%b err=%b d=%h want v=1 err=%b d=%h",
                         name, out_valid, out_err, out_rdata, e_err, e_rdata);
            end
            if (k == ordy_dly) out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, out_err, mem_req_valid, mem_req_we, mem_req_wstrb, out_rdata, mem_req_addr}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_err=%b req_v=%b req_we=%b strb=%h rdata=%h addr=%h",
                     in_ready, out_valid, out_err, mem_req_valid, mem_req_we, mem_req_wstrb, out_rdata, mem_req_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_access("lb_sext", 1, 0, 6'b001000, 4'b0000, 64'h1000_0000_0000_0003, 64'd0,
                   64'h0000_0000_8000_0000, 0, 0, 0, 0);
        run_access("lwu_zext", 1, 0, 6'b000100, 4'b0000, 64'h2000_0000_0000_0004, 64'd0,
                   64'h8765_4321_0000_0000, 0, 0, 0, 0);
        run_access("sh_lane6", 0, 1, 6'b000000, 4'b0010, 64'h3000_0000_0000_0006, 64'h0000_0000_0000_BEEF,
                   64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0);
        run_access("sw_misalign", 0, 1, 6'b000000, 4'b0001, 64'h4000_0000_0000_0002, 64'hCAFE_F00D,
                   64'd0, 0, 0, 0, 0);
        run_access("ld_misalign", 1, 0, 6'b000000, 4'b0000, 64'h4000_0000_0000_0004, 64'd0,
                   64'd0, 0, 0, 0, 0);
        run_access("noop", 0, 0, 6'b000000, 4'b0000, 64'h5000_0000_0000_0005, 64'd0,
                   64'hFFFF, 0, 0, 0, 0);
        run_access("re_we_both", 1, 1, 6'b010000, 4'b1000, 64'h6000_0000_0000_0002, 64'h1111,
                   64'h0000_0000_F00F_0000, 0, 0, 1, 0);
        run_access("ld_full", 1, 0, 6'b000000, 4'b0000, 64'h7000_0000_0000_0008, 64'd0,
                   64'hDEAD_BEEF_0123_4567, 0, 0, 2, 0);
        run_access("sd_full", 0, 1, 6'b000000, 4'b1000, 64'h7000_0000_0000_0010, 64'hA5A5_5A5A_0F0F_F0F0,
                   64'd0, 0, 0, 0, 0);
    endtask

    task automatic test_stall_and_error();
        run_access("stall_bus_err", 1, 0, 6'b100000, 4'b0000, 64'h8000_0000_0000_0004, 64'd0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1, 5, 0, 0);
        run_access("store_bus_err", 0, 1, 6'b000000, 4'b0100, 64'h8000_0000_0000_0007, 64'h77,
                   64'd0, 1, 2, 1, 0);
        run_access("out_hold", 1, 0, 6'b010000, 4'b0000, 64'h9000_0000_0000_0002, 64'd0,
                   64'h0000_0000_8001_0000, 0, 0, 0, 3);
    endtask

    task automatic test_timeout();
        run_access("timeout", 1, 0, 6'b000001, 4'b0000, 64'hA000_0000_0000_0001, 64'd0,
                   64'h55, 0, 0, -1, 0);
    endtask

    task automatic test_reset_mid_access();
        in_valid = 1'b1; in_re = 1'b1; in_we = 1'b0; in_r_wdth = 6'b000000; in_addr = 64'hB000_0000_0000_0000;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL rst_in_req: req_valid=%b in_ready=%b want 0/1", mem_req_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, in_ready, out_valid} !== 3'b010) begin
            errors++; $display("FAIL rst_in_wait: req_valid=%b in_ready=%b out_valid=%b want 0/1/0", mem_req_valid, in_ready, out_valid);
        end
        tick();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1234; mem_rsp_err = 1'b0;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready, mem_req_valid} !== 3'b010) begin
                errors++; $display("FAIL stale_rsp: out_valid=%b in_ready=%b req_valid=%b want 0/1/0", out_valid, in_ready, mem_req_valid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic re, we;
        logic [5:0] rc;
        logic [3:0] wc;
        logic [63:0] a;
        int kind, ri, wi;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            re = (kind < 5); we = (kind >= 5 && kind < 9);
            ri = $urandom_range(0, 6); wi = $urandom_range(0, 4);
            rc = (ri == 6) ? 6'b000000 : (6'b000001 << ri);
            wc = (wi == 4) ? 4'b0000 : (4'b0001 << wi);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & 3'b100;
            run_access("random", re, we, rc, wc, a, {$urandom, $urandom}, {$urandom, $urandom},
                       ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_re = 1'b0; in_we = 1'b0;
        in_r_wdth = 6'b000000; in_w_wdth = 4'b0000; in_addr = 64'd0; in_wdata = 64'd0;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'd0; mem_rsp_err = 1'b0;
        repeat (2) tick();
        test_reset();
        test_directed();
        test_stall_and_error();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
